// File: rtl/banda_alimentare.sv
// Input feeder for the assembly-line pipeline. A small FIFO buffers {a,b,c,d,e} words and
// issues at most one per clock onto registered operand bits, with a one-cycle load strobe.
module banda_alimentare #(
  parameter int W     = 5,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [W-1:0]     in_word,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  input  logic             flush,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             load,
  output logic [AW:0]      count,
  output logic [CNT_W-1:0] issued_cnt
);

  typedef enum logic [1:0] {IDLE, FEED, HOLD} state_t;

  state_t         state;
  logic [W-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           push, pop;
  logic [AW:0]    next_count;

  // Ready depends only on registered occupancy, so a pop never lets a push through.
  assign in_ready   = (count != (AW+1)'(DEPTH)) & ~flush;
  assign push       = in_valid & in_ready;
  assign pop        = (state != IDLE) & ~hold & ~flush & (count != '0);
  assign next_count = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (!clear && push) mem[wr_ptr] <= in_word;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      {a, b, c, d, e} <= '0;
      load       <= 1'b0;
      issued_cnt <= '0;
      state      <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (flush) begin
        // push is already refused while flushing, so wr_ptr is stable here
        count  <= '0;
        rd_ptr <= wr_ptr;
        load   <= 1'b0;
        state  <= IDLE;
      end else begin
        count <= next_count;
        if (pop) begin
          {a, b, c, d, e} <= mem[rd_ptr];
          rd_ptr     <= rd_ptr + 1'b1;
          load       <= 1'b1;
          issued_cnt <= issued_cnt + 1'b1;
        end else begin
          load <= 1'b0;
        end
        if (next_count == '0) state <= IDLE;
        else if (hold)        state <= HOLD;
        else                  state <= FEED;
      end
    end
  end

endmodule

// File: tb/tb_banda_alimentare.sv
// Bench for banda_alimentare: scenario tasks checked against a queue-based model of the feeder.
module tb_banda_alimentare;
  logic       clk = 1'b0;
  logic       clear = 1'b0, in_valid = 1'b0, hold = 1'b0, flush = 1'b0;
  logic [4:0] in_word = '0;
  logic       in_ready, a, b, c, d, e, load;
  logic [2:0] count;
  logic [7:0] issued_cnt;

  banda_alimentare dut (
    .clk(clk), .clear(clear), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .flush(flush), .a(a), .b(b), .c(c), .d(d), .e(e), .load(load),
    .count(count), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: the FIFO is a queue; the feeder is active whenever the queue is non-empty.
  logic [4:0] q[$];
  logic [4:0] m_word = '0;
  logic       m_load = 1'b0;
  logic [7:0] m_cnt  = '0;
  logic       rdy_obs, rdy_exp;
  logic [17:0] obs_v, exp_v;

  // Drive one cycle of inputs, advance the model across the edge, capture observed/expected.
  task automatic step(input logic v, input logic [4:0] w, input logic h, input logic f,
                      input logic cl);
    logic do_push, do_pop;
    logic [2:0] sz;
    in_valid = v; in_word = w; hold = h; flush = f; clear = cl;
    #1;
    rdy_obs = in_ready;
    rdy_exp = (q.size() != 4) && !f;
    do_push = v && rdy_exp;
    do_pop  = (q.size() > 0) && !h && !f;
    @(posedge clk);
    if (cl) begin
      q.delete(); m_word = '0; m_load = 1'b0; m_cnt = '0;
    end else if (f) begin
      q.delete(); m_load = 1'b0;
    end else begin
      if (do_pop) begin m_word = q.pop_front(); m_load = 1'b1; m_cnt = m_cnt + 8'd1; end
      else m_load = 1'b0;
      if (do_push) q.push_back(w);
    end
    #1;
    sz = 3'(q.size());
    obs_v = {load, a, b, c, d, e, count, issued_cnt, rdy_obs};
    exp_v = {m_load, m_word, sz, m_cnt, rdy_exp};
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_word = 5'b10101; clear = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 5'b10101, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL reset: got %h exp %h", obs_v, exp_v); end
    checks++;
    if ({load, a, b, c, d, e, count, issued_cnt} !== 17'd0) begin
      errors++; $display("FAIL reset_const: got %h exp 0", {load, a, b, c, d, e, count, issued_cnt});
    end
    clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [4:0] words [3];
    logic [4:0] seen  [$];
    words[0] = 5'b11100; words[1] = 5'b11110; words[2] = 5'b00011;
    for (int i = 0; i < 6; i++) begin
      step(i < 3, (i < 3) ? words[i] : 5'd0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL basic c%0d: got %h exp %h", i, obs_v, exp_v); end
      if (load) seen.push_back({a, b, c, d, e});
      // each word is on the outputs exactly one edge after its push
      if (i >= 1 && i <= 3) begin
        checks++;
        if (load !== 1'b1 || {a, b, c, d, e} !== words[i-1]) begin
          errors++; $display("FAIL basic_word%0d: got %b/%b exp 1/%b", i-1, load, {a, b, c, d, e}, words[i-1]);
        end
      end
    end
    checks++;
    if (seen.size() != 3 || issued_cnt !== 8'd3 || count !== 3'd0) begin
      errors++; $display("FAIL basic_summary: got loads=%0d cnt=%0d count=%0d exp 3/3/0", seen.size(), issued_cnt, count);
    end
  endtask

  task automatic test_hold_backpressure();
    logic [4:0] w [5];
    int k = 0;
    int loads = 0;
    for (int i = 0; i < 5; i++) w[i] = 5'($urandom);
    // hold high; present words, the 5th stays on the bus until accepted
    for (int i = 0; i < 6; i++) begin
      step(1'b1, w[k], 1'b1, 1'b0, 1'b0);
      if (rdy_obs && k < 4) k++;
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL hold c%0d: got %h exp %h", i, obs_v, exp_v); end
    end
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL hold_full: got count=%0d rdy=%b exp 4/0", count, in_ready);
    end
    for (int i = 0; i < 7; i++) begin
      step(k == 4, w[4], 1'b0, 1'b0, 1'b0);
      if (k == 4 && rdy_obs) k = 5;
      if (load) begin
        checks++;
        if ({a, b, c, d, e} !== w[loads]) begin
          errors++; $display("FAIL release_order%0d: got %b exp %b", loads, {a, b, c, d, e}, w[loads]);
        end
        loads++;
      end
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL release c%0d: got %h exp %h", i, obs_v, exp_v); end
    end
    checks++;
    if (loads != 5) begin errors++; $display("FAIL release_loads: got %0d exp 5", loads); end
  endtask

  task automatic test_flush();
    logic [4:0] prev;
    for (int i = 0; i < 3; i++) step(1'b1, 5'($urandom), 1'b1, 1'b0, 1'b0);
    prev = {a, b, c, d, e};
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL flush_pre: got %0d exp 3", count); end
    step(1'b1, 5'b01010, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL flush: got %h exp %h", obs_v, exp_v); end
    checks++;
    if (count !== 3'd0 || load !== 1'b0 || {a, b, c, d, e} !== prev) begin
      errors++; $display("FAIL flush_const: got %0d/%b/%b exp 0/0/%b", count, load, {a, b, c, d, e}, prev);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL flush_after c%0d: got %h exp %h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_wrap();
    logic [4:0] last;
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      last = 5'($urandom);
      step(1'b1, last, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL wrap c%0d: got %h exp %h", i, obs_v, exp_v); end
    end
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (issued_cnt !== 8'd0 || load !== 1'b1 || {a, b, c, d, e} !== last) begin
      errors++; $display("FAIL wrap_final: got %0d/%b/%b exp 0/1/%b", issued_cnt, load, {a, b, c, d, e}, last);
    end
  endtask

  task automatic test_clear_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 5'($urandom), 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd2 || load !== 1'b1) begin
      errors++; $display("FAIL clrmid_pre: got %0d/%b exp 2/1", count, load);
    end
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (count !== 3'd0 || load !== 1'b0) begin
      errors++; $display("FAIL clrmid: got %0d/%b exp 0/0", count, load);
    end
    step(1'b1, 5'b00011, 1'b0, 1'b0, 1'b0);
    checks++;
    if (load !== 1'b0) begin errors++; $display("FAIL clrmid_push: got load=%b exp 0", load); end
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (load !== 1'b1 || {a, b, c, d, e} !== 5'b00011) begin
      errors++; $display("FAIL clrmid_word: got %b/%b exp 1/00011", load, {a, b, c, d, e});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) != 0, 5'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL random c%0d: got %h exp %h", i, obs_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_backpressure();
    test_flush();
    test_wrap();
    test_clear_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
